// File: rtl/inert_intf_mc.sv
// Inertial sensor front end: powers up the sensor over SPI, then on each
// data-ready interrupt reads every channel and publishes the filtered words at once.

module SPI_mnrch (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt,
    input  logic [15:0] cmd,
    input  logic        MISO,
    output logic        done,
    output logic [15:0] rd_data,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI
);
    typedef enum logic {IDLE, SHIFT} spi_st_t;

    spi_st_t     st, st_nxt;
    logic [3:0]  div;
    logic [3:0]  bit_cnt;
    logic [15:0] shft;
    logic        miso_smpl;
    logic        ld, shift, fin;

    always_comb begin
        st_nxt = st;
        ld     = 1'b0;
        shift  = 1'b0;
        fin    = 1'b0;
        case (st)
            IDLE: begin
                if (wrt) begin
                    ld     = 1'b1;
                    st_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (&div) begin
                    shift = 1'b1;
                    if (&bit_cnt) begin
                        fin    = 1'b1;
                        st_nxt = IDLE;
                    end
                end
            end
            default: st_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st <= IDLE;
        else        st <= st_nxt;
    end

    // SCLK low for div 0..7, high for 8..15; MISO is sampled just before the rising edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div       <= 4'd0;
            bit_cnt   <= 4'd0;
            shft      <= 16'h0000;
            miso_smpl <= 1'b0;
            SS_n      <= 1'b1;
            done      <= 1'b0;
        end else begin
            done <= fin;
            if (ld) begin
                shft    <= cmd;
                div     <= 4'd0;
                bit_cnt <= 4'd0;
                SS_n    <= 1'b0;
            end else if (st == SHIFT) begin
                div <= div + 4'd1;
                if (div == 4'd7) miso_smpl <= MISO;
                if (shift) begin
                    shft    <= {shft[14:0], miso_smpl};
                    bit_cnt <= bit_cnt + 4'd1;
                end
                if (fin) SS_n <= 1'b1;
            end
        end
    end

    assign SCLK    = (st == SHIFT) ? div[3] : 1'b1;
    assign MOSI    = shft[15];
    assign rd_data = shft;
endmodule

module inert_intf_mc #(
    parameter int                  NUM_CH   = 2,
    parameter logic [8*NUM_CH-1:0] CH_ADDR  = {8'h2C, 8'h22},
    parameter int                  PWRUP_W  = 16,
    parameter int                  GAP_W    = 10,
    parameter int                  TO_W     = 20,
    parameter bit                  FILT_EN  = 1'b1,
    parameter logic [15:0]         FILT_LIM = 16'h1F00
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   clr_err,
    input  logic                   INT,
    input  logic                   MISO,
    output logic                   SS_n,
    output logic                   SCLK,
    output logic                   MOSI,
    output logic [16*NUM_CH-1:0]   ch_data,
    output logic                   vld,
    output logic                   timeout
);
    localparam int                IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [IDX_W-1:0]  LAST  = IDX_W'(NUM_CH - 1);
    localparam logic signed [15:0] LIM_P = FILT_LIM;
    localparam logic signed [15:0] LIM_N = ~FILT_LIM + 16'd1;

    typedef enum logic [2:0] {INIT1, INIT2, INIT3, INIT4, WAIT, RDL, RDH, DONE} state_t;

    state_t                  state, nxt;
    logic                    int_ff1, int_s;
    logic [PWRUP_W-1:0]      pwr_cnt;
    logic [GAP_W-1:0]        gap_cnt;
    logic [TO_W-1:0]         to_cnt;
    logic [IDX_W-1:0]        ch_idx;
    logic [NUM_CH-1:0][15:0] shd;

    logic        wrt, done;
    logic [15:0] cmd, rd_data;
    logic        gap_clr, idx_clr, idx_inc, cap_lo, cap_hi, publish;
    logic [7:0]  cur_lo, nxt_lo;
    logic        pwr_full, gap_full, to_run;
    logic        unused_rd;

    function automatic logic [7:0] ch_addr(input logic [IDX_W-1:0] k);
        return CH_ADDR[8*k +: 8];
    endfunction

    function automatic logic [15:0] rd_cmd(input logic [7:0] a);
        return {a | 8'h80, 8'h00};
    endfunction

    // Readings outside +/-FILT_LIM are treated as glitches and zeroed
    function automatic logic [15:0] filt(input logic [15:0] w);
        if (FILT_EN && ($signed(w) > LIM_P || $signed(w) < LIM_N)) return 16'h0000;
        return w;
    endfunction

    assign cur_lo    = ch_addr(ch_idx);
    assign nxt_lo    = ch_addr(ch_idx + IDX_W'(1));
    assign pwr_full  = &pwr_cnt;
    assign gap_full  = &gap_cnt;
    assign to_run    = (state == WAIT) && en && !int_s;
    assign unused_rd = ^rd_data[15:8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_ff1 <= 1'b0;
            int_s   <= 1'b0;
        end else begin
            int_ff1 <= INT;
            int_s   <= int_ff1;
        end
    end

    always_comb begin
        nxt     = state;
        wrt     = 1'b0;
        cmd     = 16'h0000;
        gap_clr = 1'b0;
        idx_clr = 1'b0;
        idx_inc = 1'b0;
        cap_lo  = 1'b0;
        cap_hi  = 1'b0;
        publish = 1'b0;
        case (state)
            INIT1: if (pwr_full) begin
                wrt = 1'b1; cmd = 16'h0D02; gap_clr = 1'b1; nxt = INIT2;
            end
            INIT2: if (gap_full) begin
                wrt = 1'b1; cmd = 16'h1053; gap_clr = 1'b1; nxt = INIT3;
            end
            INIT3: if (gap_full) begin
                wrt = 1'b1; cmd = 16'h1150; gap_clr = 1'b1; nxt = INIT4;
            end
            INIT4: if (gap_full) begin
                wrt = 1'b1; cmd = 16'h1460; gap_clr = 1'b1; nxt = WAIT;
            end
            WAIT: if (en && int_s) begin
                idx_clr = 1'b1;
                gap_clr = 1'b1;
                wrt     = 1'b1;
                cmd     = rd_cmd(ch_addr('0));
                nxt     = RDL;
            end
            RDL: begin
                cap_lo = done;
                if (gap_full) begin
                    wrt     = 1'b1;
                    cmd     = rd_cmd(cur_lo + 8'd1);
                    gap_clr = 1'b1;
                    nxt     = RDH;
                end
            end
            RDH: begin
                cap_hi = done;
                if (gap_full) begin
                    if (ch_idx != LAST) begin
                        idx_inc = 1'b1;
                        wrt     = 1'b1;
                        cmd     = rd_cmd(nxt_lo);
                        gap_clr = 1'b1;
                        nxt     = RDL;
                    end else begin
                        nxt = DONE;
                    end
                end
            end
            DONE: begin
                publish = 1'b1;
                gap_clr = 1'b1;
                nxt     = WAIT;
            end
            default: nxt = INIT1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= INIT1;
        else        state <= nxt;
    end

    // Counters saturate at all-ones so a late transition still sees "reached"
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwr_cnt <= '0;
            gap_cnt <= '0;
            ch_idx  <= '0;
        end else begin
            if (state == INIT1 && !pwr_full) pwr_cnt <= pwr_cnt + PWRUP_W'(1);
            if (gap_clr)        gap_cnt <= '0;
            else if (!gap_full) gap_cnt <= gap_cnt + GAP_W'(1);
            if (idx_clr)        ch_idx <= '0;
            else if (idx_inc)   ch_idx <= ch_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shd <= '0;
        end else begin
            if (cap_lo) shd[ch_idx][7:0]  <= rd_data[7:0];
            if (cap_hi) shd[ch_idx][15:8] <= rd_data[7:0];
        end
    end

    // Shadow words reach ch_data only together, in the vld cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_data <= '0;
            vld     <= 1'b0;
        end else begin
            vld <= publish;
            if (publish) begin
                for (int k = 0; k < NUM_CH; k++) ch_data[16*k +: 16] <= filt(shd[k]);
            end
        end
    end

    // Watchdog wraps to zero on expiry so a dead sensor keeps re-flagging
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            if (to_run)              to_cnt <= to_cnt + TO_W'(1);
            else if (state != WAIT)  to_cnt <= '0;
            if (clr_err)                  timeout <= 1'b0;
            else if (to_run && &to_cnt)   timeout <= 1'b1;
        end
    end

    SPI_mnrch u_spi (
        .clk     (clk),
        .rst_n   (rst_n),
        .wrt     (wrt),
        .cmd     (cmd),
        .MISO    (MISO),
        .done    (done),
        .rd_data (rd_data),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI)
    );
endmodule

// File: tb/tb_inert_intf_mc.sv
// Directed bench: two DUTs (2-ch filtered, 4-ch raw) each talking to a small SPI sensor model.

module tb_inert_intf_mc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic clr_err = 1'b0;
    logic int_a = 1'b0;
    logic int_b = 1'b0;

    logic        ss_n_a, sclk_a, mosi_a, miso_a, vld_a, timeout_a;
    logic        ss_n_b, sclk_b, mosi_b, miso_b, vld_b, timeout_b;
    logic [31:0] ch_data_a;
    logic [63:0] ch_data_b;

    logic [7:0] mem [2][128];

    int checks = 0;
    int failures = 0;
    int vld_cnt_a = 0;
    int vld_cnt_b = 0;
    int bad_a = 0;
    int bad_b = 0;
    logic [31:0] prev_a = '0;
    logic [63:0] prev_b = '0;

    always #5 clk = ~clk;

    inert_intf_mc #(
        .NUM_CH(2), .CH_ADDR(16'h2C22), .PWRUP_W(6), .GAP_W(9), .TO_W(10),
        .FILT_EN(1'b1), .FILT_LIM(16'h1F00)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .clr_err(clr_err), .INT(int_a), .MISO(miso_a),
        .SS_n(ss_n_a), .SCLK(sclk_a), .MOSI(mosi_a), .ch_data(ch_data_a), .vld(vld_a),
        .timeout(timeout_a)
    );

    inert_intf_mc #(
        .NUM_CH(4), .CH_ADDR(32'h40302C22), .PWRUP_W(6), .GAP_W(9), .TO_W(10),
        .FILT_EN(1'b0), .FILT_LIM(16'h1F00)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .clr_err(clr_err), .INT(int_b), .MISO(miso_b),
        .SS_n(ss_n_b), .SCLK(sclk_b), .MOSI(mosi_b), .ch_data(ch_data_b), .vld(vld_b),
        .timeout(timeout_b)
    );

    // Sensor model: first byte is the command, second byte returns mem[addr] MSB first
    for (genvar b = 0; b < 2; b++) begin : g_slv
        logic        ss, sck, mo;
        logic        miso = 1'b0;
        int          rx_cnt = 0;
        logic [15:0] cmd_sh = '0;
        logic [7:0]  tx = '0;
        logic [15:0] cmd_q [$];
        time         start_q [$];

        assign ss  = (b == 0) ? ss_n_a : ss_n_b;
        assign sck = (b == 0) ? sclk_a : sclk_b;
        assign mo  = (b == 0) ? mosi_a : mosi_b;

        always @(posedge sck or posedge ss) begin
            if (ss) begin
                rx_cnt <= 0;
            end else begin
                cmd_sh <= {cmd_sh[14:0], mo};
                rx_cnt <= rx_cnt + 1;
                if (rx_cnt == 15) cmd_q.push_back({cmd_sh[14:0], mo});
            end
        end

        always @(negedge sck) begin
            if (!ss) begin
                if (rx_cnt == 8) begin
                    miso <= mem[b][cmd_sh[6:0]][7];
                    tx   <= mem[b][cmd_sh[6:0]] << 1;
                end else if (rx_cnt > 8) begin
                    miso <= tx[7];
                    tx   <= tx << 1;
                end
            end
        end

        always @(negedge ss) start_q.push_back($time);
    end

    assign miso_a = g_slv[0].miso;
    assign miso_b = g_slv[1].miso;

    always @(posedge clk) begin
        if (vld_a) vld_cnt_a <= vld_cnt_a + 1;
        if (vld_b) vld_cnt_b <= vld_cnt_b + 1;
    end

    always @(negedge clk) begin
        if (rst_n && ch_data_a !== prev_a && !vld_a) bad_a <= bad_a + 1;
        if (rst_n && ch_data_b !== prev_b && !vld_b) bad_b <= bad_b + 1;
        prev_a <= ch_data_a;
        prev_b <= ch_data_b;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_a(input logic [15:0] c0, input logic [15:0] c1);
        mem[0][7'h22] = c0[7:0];  mem[0][7'h23] = c0[15:8];
        mem[0][7'h2C] = c1[7:0];  mem[0][7'h2D] = c1[15:8];
    endtask

    task automatic kick_a();
        en = 1'b1;
        int_a = 1'b1;
        repeat (5) @(negedge clk);
        int_a = 1'b0;
        en = 1'b0;
    endtask

    task automatic wait_vld_a(input int n);
        for (int c = 0; c < 3000 && vld_cnt_a < n; c++) @(negedge clk);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        time t_rel;
        int  base, sbase, va, c;

        repeat (3) @(negedge clk);
        chk("rst_ss_n", ss_n_a, 1);
        chk("rst_ch_data", ch_data_a, 0);
        chk("rst_vld", vld_a, 0);
        chk("rst_timeout", timeout_a, 0);

        // Init sequence
        t_rel = $time;
        rst_n = 1'b1;
        for (int i = 0; i < 2500 && g_slv[0].cmd_q.size() < 4; i++) @(negedge clk);
        chk("init_count", g_slv[0].cmd_q.size(), 4);
        chk("init_w0", g_slv[0].cmd_q[0], 16'h0D02);
        chk("init_w1", g_slv[0].cmd_q[1], 16'h1053);
        chk("init_w2", g_slv[0].cmd_q[2], 16'h1150);
        chk("init_w3", g_slv[0].cmd_q[3], 16'h1460);
        chk("init_first_time", g_slv[0].start_q[0] - t_rel, 64'd635);
        for (int i = 1; i < 4; i++)
            chk("init_spacing", g_slv[0].start_q[i] - g_slv[0].start_q[i-1], 64'd5120);
        chk("b_init_count", g_slv[1].cmd_q.size(), 4);
        repeat (300) @(negedge clk);

        // Plain read, en dropped mid-sequence
        load_a(16'h1234, 16'hF00A);
        base = g_slv[0].cmd_q.size();
        kick_a();
        wait_vld_a(1);
        chk("rd_cmd0", g_slv[0].cmd_q[base],   16'hA200);
        chk("rd_cmd1", g_slv[0].cmd_q[base+1], 16'hA300);
        chk("rd_cmd2", g_slv[0].cmd_q[base+2], 16'hAC00);
        chk("rd_cmd3", g_slv[0].cmd_q[base+3], 16'hAD00);
        chk("rd_count", g_slv[0].cmd_q.size() - base, 4);
        chk("rd_data", ch_data_a, 32'hF00A_1234);
        chk("rd_vld_cnt", vld_cnt_a, 1);

        // Just outside the limit on both sides
        load_a(16'h1F01, 16'hE0FF);
        kick_a();
        wait_vld_a(2);
        chk("filt_out", ch_data_a, 32'h0000_0000);
        chk("filt_out_vld", vld_cnt_a, 2);

        // Exactly at the limit passes
        load_a(16'h1F00, 16'hE100);
        kick_a();
        wait_vld_a(3);
        chk("filt_edge", ch_data_a, 32'hE100_1F00);

        // Watchdog
        sbase = g_slv[0].start_q.size();
        en = 1'b1;
        c = 0;
        while (!timeout_a && c < 1200) begin
            @(negedge clk);
            c++;
        end
        chk("to_set", timeout_a, 1);
        chk("to_latency", c, 1024);
        chk("to_no_spi", g_slv[0].start_q.size() - sbase, 0);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("to_clr", timeout_a, 0);
        clr_err = 1'b1;
        repeat (1100) @(negedge clk);
        chk("to_clr_wins", timeout_a, 0);
        clr_err = 1'b0;
        load_a(16'h0005, 16'hFFFB);
        kick_a();
        wait_vld_a(4);
        chk("to_then_read", ch_data_a, 32'hFFFB_0005);
        chk("to_after_read", timeout_a, 0);

        // Reset during RDH of channel 1
        load_a(16'h1111, 16'h2222);
        sbase = g_slv[0].start_q.size();
        kick_a();
        for (int i = 0; i < 2500 && g_slv[0].start_q.size() < sbase + 4; i++) @(negedge clk);
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        va = vld_cnt_a;
        repeat (2) @(negedge clk);
        chk("mid_rst_data", ch_data_a, 0);
        chk("mid_rst_vld", vld_a, 0);
        chk("mid_rst_ss_n", ss_n_a, 1);
        base = g_slv[0].cmd_q.size();
        rst_n = 1'b1;
        for (int i = 0; i < 2500 && g_slv[0].cmd_q.size() < base + 4; i++) @(negedge clk);
        chk("reinit_w0", g_slv[0].cmd_q[base], 16'h0D02);
        chk("reinit_w3", g_slv[0].cmd_q[base+3], 16'h1460);
        repeat (300) @(negedge clk);
        chk("reinit_data", ch_data_a, 0);
        chk("reinit_no_vld", vld_cnt_a, va);

        // Four channels, raw, extra INT during RDL
        mem[1][7'h22] = 8'h00;  mem[1][7'h23] = 8'h80;
        mem[1][7'h2C] = 8'h01;  mem[1][7'h2D] = 8'h1F;
        mem[1][7'h30] = 8'h34;  mem[1][7'h31] = 8'h12;
        mem[1][7'h40] = 8'hFF;  mem[1][7'h41] = 8'hE0;
        base  = g_slv[1].cmd_q.size();
        sbase = g_slv[1].start_q.size();
        en = 1'b1;
        int_b = 1'b1;
        repeat (5) @(negedge clk);
        int_b = 1'b0;
        repeat (100) @(negedge clk);
        int_b = 1'b1;
        repeat (5) @(negedge clk);
        int_b = 1'b0;
        en = 1'b0;
        for (int i = 0; i < 5000 && vld_cnt_b < 1; i++) @(negedge clk);
        chk("b_vld", vld_cnt_b, 1);
        chk("b_cmd_count", g_slv[1].cmd_q.size() - base, 8);
        chk("b_cmd_first", g_slv[1].cmd_q[base], 16'hA200);
        chk("b_cmd_ch2lo", g_slv[1].cmd_q[base+4], 16'hB000);
        chk("b_cmd_last", g_slv[1].cmd_q[base+7], 16'hC100);
        chk("b_data", ch_data_b, 64'hE0FF_1234_1F01_8000);
        repeat (200) @(negedge clk);
        chk("b_no_extra_spi", g_slv[1].start_q.size() - sbase, 8);
        chk("b_single_vld", vld_cnt_b, 1);

        chk("a_no_partial_update", bad_a, 0);
        chk("b_no_partial_update", bad_b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
